uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial-to-AXI-stream UART receiver; the downstream peer of uart_tx.
//  - Samples the 8N1 serial line rx and emits each byte on an AXI-stream master (tvalid/tready/tdata).
//  - Flags framing errors and overflow as pulses.
//  - Lives in the UART example and closes the loopback: uart_tx.tx -> uart_rx.rx.
// PARAMETERS
//  cycles_per_bit  434  clk cycles per serial bit (50 MHz / 115200); must be >= 4
// PORTS
//  clk             in   1  system clock; all logic on rising edge
//  rst_n           in   1  synchronous, active-low reset
//  rx              in   1  asynchronous serial input, idle high
//  tready          in   1  AXI-stream: consumer ready
//  tvalid          out  1  AXI-stream: tdata holds a received byte
//  tdata           out  8  AXI-stream: received byte, LSB first on wire
//  framing_error   out  1  1-cycle pulse: stop bit sampled low
//  overflow        out  1  1-cycle pulse: byte completed while tvalid && !tready
//  parity_error    out  1  1-cycle pulse: parity mismatch (tied 0 without UART_RX_PARITY_EN)
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state=IDLE, counters 0, synchronizer=1, tvalid=0, tdata=0, all pulses 0.
//    Mid-frame reset discards the partial byte and any held output byte.
//  - rx passes a 2-FF synchronizer (reset value 1); all decisions use the synchronized rx_s.
//  - Bit counter width: $clog2(cycles_per_bit). Sample point = counter reaching cycles_per_bit/2 (floor).
//  - FSM: IDLE, START, DATA, [PARITY], STOP, WAIT_IDLE.
//    IDLE: rx_s==0 -> START, counter cleared.
//    START: at half-bit, if rx_s==0 -> DATA (counter restarts, full-bit spacing from here);
//      if rx_s==1 -> IDLE (glitch rejected, no output).
//    DATA: sample at each full-bit interval into shift reg, LSB first; after bit 7 -> PARITY or STOP.
//    STOP: sample once.
//      rx_s==1 -> deliver byte, -> IDLE.
//      rx_s==0 -> framing_error pulse, byte dropped, -> WAIT_IDLE.
//    WAIT_IDLE: stay until rx_s==1, then IDLE (no false start on a held-low break).
//  - Delivery: tvalid rises the cycle after the stop-bit sample edge; tdata stable while tvalid.
//  - Handshake: transfer when tvalid && tready at a clk edge; tvalid drops next cycle unless a new byte
//    completes that same cycle, in which case tdata updates and tvalid stays 1.
//  - Overflow: byte completes while tvalid && !tready -> overflow pulse; the NEW byte is dropped,
//    the held byte is kept.
//  - tvalid never depends combinationally on tready.
//  - Receiver is ready for the next start bit immediately after the stop sample (half-bit slack);
//    back-to-back frames at full baud are received without loss.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    - 8E1 framing. PARITY state samples one bit after data bit 7.
//    - Mismatch against even parity of the data -> parity_error pulse at stop sample; byte dropped.
//    - framing_error takes precedence (only framing_error pulses).
//  UART_RX_PARITY_EN undefined: 8N1, no PARITY state, parity_error constantly 0.
// STRUCTURE
//  - uart_pkg:
//    - typedef enum logic [2:0] uart_rx_state_t {IDLE,START,DATA,PARITY,STOP,WAIT_IDLE}
//    - localparam DATA_BITS=8
//    - function even_parity(logic [7:0]); shared with uart_tx.
//  - Sub-module uart_sync2: generic 2-FF synchronizer with reset value parameter.
// TESTING (cycles_per_bit=434, clk 20 ns, bit time 8680 ns)
//  1. Drive frame 0xA5, tready=1 -> one tvalid beat, tdata=0xA5, no error pulses.
//  2. 7 random bytes back-to-back, tready=1 -> 7 beats, same order, overflow never pulses.
//  3. rx low for 2000 ns then high -> no tvalid, no framing_error, FSM back in IDLE.
//  4. Frame 0x3C with stop bit low, rx held low 3 bit times -> framing_error once, no tvalid; next frame
//     0x81 received correctly.
//  5. tready=0, send 0x11 then 0x22 -> tvalid with 0x11, overflow pulses once; raise tready -> only 0x11
//     delivered.
//  6. rst_n=0 for 1 cycle during data bit 4 of 0x55 -> tvalid stays 0; following frame 0x0F received.
//  (Parity build: 0x07 with odd parity bit -> parity_error once, no tvalid.)

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and parity helper.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_rx_state_t;

    // Even parity bit: makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [7:0] i_data);
        return ^i_data;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer with a configurable synchronous reset value.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_ff;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ff <= {2{RESET_VAL}};
        end else begin
            r_ff <= {r_ff[0], i_d};
        end
    end

    assign o_q = r_ff[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with AXI-stream output; define UART_RX_PARITY_EN for 8E1 framing
// with parity checking.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned cycles_per_bit = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       tready,
    output logic       tvalid,
    output logic [7:0] tdata,
    output logic       framing_error,
    output logic       overflow,
    output logic       parity_error
);

    localparam int unsigned CNT_W = $clog2(cycles_per_bit);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(cycles_per_bit / 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(cycles_per_bit - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic                 w_rx_s;
    uart_rx_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 w_done, w_fe;
    logic                 r_tvalid, r_fe, r_ov;
    logic [7:0]           r_tdata;
`ifdef UART_RX_PARITY_EN
    logic                 r_par, w_par_nxt;
    logic                 w_pe, r_pe;
`endif

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    // FSM and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_done      = 1'b0;
        w_fe        = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt   = r_par;
        w_pe        = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (!w_rx_s) w_state_nxt = START;
            end
            START: begin
                // Mid-start check; a line already back high was a glitch.
                if (r_cnt == HALF_CNT) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == FULL_CNT) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    if (r_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (r_cnt == FULL_CNT) begin
                    w_cnt_nxt   = '0;
                    w_par_nxt   = w_rx_s;
                    w_state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (r_cnt == FULL_CNT) begin
                    w_cnt_nxt = '0;
                    if (!w_rx_s) begin
                        w_fe        = 1'b1;
                        w_state_nxt = WAIT_IDLE;
                    end else begin
`ifdef UART_RX_PARITY_EN
                        if (r_par != even_parity(r_shift)) w_pe = 1'b1;
                        else                               w_done = 1'b1;
`else
                        w_done = 1'b1;
`endif
                        w_state_nxt = IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                w_cnt_nxt = '0;
                if (w_rx_s) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Stream output and error pulses; a held byte wins over a newly completed one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_fe     <= 1'b0;
            r_ov     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_pe     <= 1'b0;
`endif
        end else begin
            r_fe <= w_fe;
            r_ov <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_pe <= w_pe;
`endif
            if (w_done) begin
                if (r_tvalid && !tready) begin
                    r_ov <= 1'b1;
                end else begin
                    r_tvalid <= 1'b1;
                    r_tdata  <= r_shift;
                end
            end else if (tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign tvalid        = r_tvalid;
    assign tdata         = r_tdata;
    assign framing_error = r_fe;
    assign overflow      = r_ov;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = r_pe;
`else
    assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames built from byte values, received beats
// compared against a queue of expected bytes.
module tb_uart_rx;

    localparam int CPB = 434;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       tready;
    logic       tvalid;
    logic [7:0] tdata;
    logic       framing_error;
    logic       overflow;
    logic       parity_error;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int rd_ptr   = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int pe_cnt   = 0;
    int unstable = 0;
    int fe0, ov0, pe0;

    logic       p_valid = 1'b0;
    logic       p_ready = 1'b0;
    logic [7:0] p_data  = '0;

    uart_rx #(.cycles_per_bit(CPB)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .tready        (tready),
        .tvalid        (tvalid),
        .tdata         (tdata),
        .framing_error (framing_error),
        .overflow      (overflow),
        .parity_error  (parity_error)
    );

    always #10 clk = ~clk;

    // Observe accepted beats, pulses and data stability away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tvalid && tready) got_q.push_back(tdata);
            if (framing_error) fe_cnt++;
            if (overflow)      ov_cnt++;
            if (parity_error)  pe_cnt++;
            if (p_valid && !p_ready && tvalid && tdata != p_data) unstable++;
        end
        p_valid = tvalid;
        p_ready = tready;
        p_data  = tdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        pe0 = pe_cnt;
    endtask

    task automatic check_pulses(input string tag, input int fe, input int ov, input int pe);
        check({tag, "_fe"}, 32'(fe_cnt - fe0), 32'(fe));
        check({tag, "_ov"}, 32'(ov_cnt - ov0), 32'(ov));
        check({tag, "_pe"}, 32'(pe_cnt - pe0), 32'(pe));
    endtask

    // Compare beats received since the last call against the expected byte queue.
    task automatic check_beats(input string tag);
        int n_new;
        n_new = got_q.size() - rd_ptr;
        check({tag, "_count"}, 32'(n_new), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n_new; i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(got_q[rd_ptr + i]), 32'(exp_q[i]));
        rd_ptr = got_q.size();
        exp_q.delete();
    endtask

    // One frame: start, 8 data bits LSB first, [parity], stop level held stop_bits bit times.
    // rst_bit >= 0 pulses reset mid data bit rst_bit; the sending peer restarts too, so the line idles.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int stop_bits,
                              input logic par_ok, input int rst_bit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == rst_bit) begin
                tick(CPB / 2);
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
                rx = 1'b1;
                tick(CPB * (10 - i));
                return;
            end
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_ok ? ^d : ~(^d);
        tick(CPB);
`else
        if (!par_ok) $display("note: parity flag ignored in 8N1 build");
`endif
        rx = stop_bit;
        tick(CPB * stop_bits);
        rx = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        rst_n  = 1'b0;
        rx     = 1'b1;
        tready = 1'b1;
        tick(3);
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tdata", 32'(tdata), 32'd0);
        check("rst_fe", 32'(framing_error), 32'd0);
        check("rst_ov", 32'(overflow), 32'd0);
        check("rst_pe", 32'(parity_error), 32'd0);
        rst_n = 1'b1;
        tick(5);

        // Single frame
        snap();
        send_frame(8'hA5, 1'b1, 1, 1'b1, -1);
        tick(20);
        exp_q.push_back(8'hA5);
        check_beats("t1");
        check_pulses("t1", 0, 0, 0);

        // Back-to-back random bytes at full baud
        snap();
        for (int i = 0; i < 7; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1, 1, 1'b1, -1);
        end
        tick(20);
        check_beats("t2");
        check_pulses("t2", 0, 0, 0);

        // Short low glitch is rejected
        snap();
        rx = 1'b0;
        tick(100);
        rx = 1'b1;
        tick(2 * CPB);
        check_beats("t3");
        check_pulses("t3", 0, 0, 0);

        // Bad stop bit with a held-low break, then a good frame
        snap();
        send_frame(8'h3C, 1'b0, 3, 1'b1, -1);
        tick(CPB);
        send_frame(8'h81, 1'b1, 1, 1'b1, -1);
        tick(20);
        exp_q.push_back(8'h81);
        check_beats("t4");
        check_pulses("t4", 1, 0, 0);

        // Overflow: second byte completes while the first is still held
        snap();
        tready = 1'b0;
        send_frame(8'h11, 1'b1, 1, 1'b1, -1);
        send_frame(8'h22, 1'b1, 1, 1'b1, -1);
        tick(20);
        check("t5_held_valid", 32'(tvalid), 32'd1);
        check("t5_held_data", 32'(tdata), 32'h11);
        check_pulses("t5", 0, 1, 0);
        tready = 1'b1;
        tick(3);
        check("t5_drop_valid", 32'(tvalid), 32'd0);
        exp_q.push_back(8'h11);
        check_beats("t5");

        // Mid-frame reset discards the partial byte
        snap();
        send_frame(8'h55, 1'b1, 1, 1'b1, 4);
        check("t6_valid_after_rst", 32'(tvalid), 32'd0);
        check_beats("t6_partial");
        send_frame(8'h0F, 1'b1, 1, 1'b1, -1);
        tick(20);
        exp_q.push_back(8'h0F);
        check_beats("t6");
        check_pulses("t6", 0, 0, 0);

`ifdef UART_RX_PARITY_EN
        // Wrong parity bit drops the byte
        snap();
        send_frame(8'h07, 1'b1, 1, 1'b0, -1);
        tick(20);
        check_beats("t7");
        check_pulses("t7", 0, 0, 1);
`endif

        check("tdata_stable", 32'(unstable), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
